// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: FSM states, command byte layout and constants shared by the SPI command controller
package spi_cmd_pkg;
  typedef enum logic [1:0] {IDLE, WDATA, RDUMMY} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h81;
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_W = 2;
  localparam int NUM_REGS = 4;
  function automatic logic cmd_ok(input logic [7:0] b);
    return b[CMD_WRITE_BIT-1:CMD_ADDR_LSB+CMD_ADDR_W] == '0;
  endfunction
endpackage

// File: rtl/spi_frame_timeout.sv
// spi_frame_timeout: flags the CYCLES-th consecutive enabled cycle without a clear
module spi_frame_timeout #(
  parameter int CYCLES = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] count;
  assign expired = enable && !clear && count == W'(CYCLES - 1);
  always_ff @(posedge clk)
    count <= rst || clear || !enable || expired ? '0 : count + 1'b1;
endmodule

// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller: SPI command decoder driving a 4x8 register file.
// Define SPI_CMD_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES cycles.
module spi_cmd_controller
  import spi_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [7:0]               tx_byte,
  output logic [8*NUM_REGS-1:0]    regs,
  output logic                     wr_strobe,
  output logic [CMD_ADDR_W-1:0]    wr_addr,
  output logic                     busy,
  output logic [7:0]               err_count
);
  state_t state, state_next;
  logic [NUM_REGS-1:0][7:0] rf;
  logic [CMD_ADDR_W-1:0] addr_q, addr_next, wr_addr_next, cmd_addr;
  logic [7:0] tx_next, err_next;
  logic accept, reject, do_write, timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef SPI_CMD_TIMEOUT_EN
  spi_frame_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clear(rx_valid),
    .enable(state != IDLE),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign regs = rf;
  assign cmd_addr = rx_byte[CMD_ADDR_LSB +: CMD_ADDR_W];
  assign accept = state == IDLE && rx_valid && cmd_ok(rx_byte);
  assign do_write = state == WDATA && rx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rf <= '0;
      addr_q <= '0;
      tx_byte <= SYNC_BYTE;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      busy <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_next;
      addr_q <= addr_next;
      tx_byte <= tx_next;
      wr_strobe <= do_write;
      wr_addr <= wr_addr_next;
      busy <= state_next != IDLE;
      err_count <= err_next;
      if (do_write) rf[addr_q] <= rx_byte;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          state_next = accept ? (rx_byte[CMD_WRITE_BIT] ? WDATA : RDUMMY) : IDLE;
      WDATA, RDUMMY: state_next = rx_valid || timeout ? IDLE : state;
      default:       state_next = IDLE;
    endcase
  end

  // tx_byte holds the read data only while the dummy byte is awaited
  always_comb begin
    tx_next = accept && !rx_byte[CMD_WRITE_BIT] ? rf[cmd_addr]
            : state_next == RDUMMY ? tx_byte : SYNC_BYTE;
    addr_next = accept ? cmd_addr : addr_q;
    wr_addr_next = do_write ? addr_q : wr_addr;
    reject = (state == IDLE && rx_valid && !cmd_ok(rx_byte)) || timeout;
    err_next = reject && err_count != 8'hFF ? err_count + 8'd1 : err_count;
  end
endmodule

// File: doc/spi_cmd_controller.md
SPI_CMD_CONTROLLER -- requirements
Module: spi_cmd_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16000, meaning idle cycles before a mid-frame abort (1 ms at 16 MHz).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port rx_byte, input, 8, the byte most recently received from the SPI byte reader.
REQ-005 The block SHALL have port rx_valid, input, 1, a one-cycle pulse marking rx_byte as new.
REQ-006 The block SHALL have port tx_byte, output, 8, the byte the SPI reader shifts out on MISO during the next transfer.
REQ-007 The block SHALL have port regs, output, 32, the register file flattened: reg[n] on bits 8n+7:8n.
REQ-008 The block SHALL have port wr_strobe, output, 1, a one-cycle pulse on any register write.
REQ-009 The block SHALL have port wr_addr, output, 2, the index of the register written, valid with wr_strobe.
REQ-010 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port err_count, output, 8, a saturating count of rejected command bytes.

Function
REQ-012 The FSM SHALL have states IDLE, WDATA and RDUMMY; it SHALL act only on cycles where rx_valid=1, except on timeout.
REQ-013 In IDLE, a command byte SHALL decode as bit7=write(1)/read(0), bits1:0=addr, bits6:2 required zero.
REQ-014 A command byte with bits6:2 nonzero SHALL be rejected: the FSM SHALL stay in IDLE and err_count SHALL increment, holding at 255.
REQ-015 A valid write command SHALL latch addr and move the FSM to WDATA; the next rx_valid SHALL write rx_byte to reg[addr], pulse wr_strobe and drive wr_addr on the following cycle, and return the FSM to IDLE.
REQ-016 A valid read command SHALL load tx_byte with reg[addr] one cycle after rx_valid and move the FSM to RDUMMY; the next rx_valid SHALL be discarded, tx_byte SHALL return to SYNC_BYTE and the FSM SHALL return to IDLE.
REQ-017 In IDLE and WDATA, tx_byte SHALL equal SYNC_BYTE (8'h81).
REQ-018 regs SHALL change only through REQ-015; a read SHALL NOT modify any register.
REQ-019 rx_valid in the same cycle as rst SHALL be ignored.
REQ-020 busy SHALL be registered and SHALL be high in the cycle after each transition out of IDLE.

Reset
REQ-021 On rst=1 the block SHALL set the FSM to IDLE, all regs to 0, tx_byte to 8'h81, wr_strobe to 0, wr_addr to 0, busy to 0, err_count to 0 and the timeout counter to 0.
REQ-022 rst asserted mid-frame SHALL abandon the frame with no register write.

Configuration
REQ-023 When macro SPI_CMD_TIMEOUT_EN is defined, a counter SHALL count cycles in WDATA or RDUMMY without rx_valid.
REQ-024 With SPI_CMD_TIMEOUT_EN defined, the counter SHALL clear on each rx_valid; on reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE, tx_byte SHALL become SYNC_BYTE, no write SHALL occur and err_count SHALL increment.
REQ-025 Without SPI_CMD_TIMEOUT_EN, no counter SHALL be synthesised and the FSM SHALL wait in WDATA or RDUMMY indefinitely.

Structure
REQ-026 A shared package spi_cmd_pkg SHALL hold the state enumeration, SYNC_BYTE=8'h81, the command bit positions (CMD_WRITE_BIT=7, CMD_ADDR_LSB=0, CMD_ADDR_W=2) and NUM_REGS=4.
REQ-027 The timeout SHALL be a sub-module spi_frame_timeout (clear, enable, expired) instantiated only under SPI_CMD_TIMEOUT_EN; the register file SHALL stay inline.

Verification
REQ-028 Write: bytes 8'h82 then 8'h5A -> reg[2]=8'h5A, wr_strobe one cycle with wr_addr=2, regs=32'h005A0000.
REQ-029 Read-back: after REQ-028, byte 8'h02 -> tx_byte=8'h5A next cycle; dummy 8'h00 -> tx_byte=8'h81, regs unchanged.
REQ-030 Bad command: byte 8'h7C -> FSM stays IDLE, err_count=1; 300 bad bytes -> err_count=255.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=10): byte 8'h81, then 10 idle cycles -> busy=0, no write, err_count=1; next 8'h33 treated as a command.
REQ-032 Reset mid-frame: byte 8'h81, rst one cycle, then 8'hFF -> reg[1]=0, 8'hFF rejected, err_count=1.
REQ-033 Back-to-back: rx_valid on consecutive cycles with 8'h80, 8'h11, 8'h00 -> reg[0]=8'h11, tx_byte=8'h11 after the third byte.
